// File: rtl/binary_divider_seq_if.sv
// Handshake and operand/result bundle for binary_divider_seq.
// The master drives start/A/B; the slave (divider) returns Q/R and status.
interface binary_divider_seq_if #(
    parameter int n = 4
);
    logic         start;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic [n-1:0] Q;
    logic [n-1:0] R;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, div_by_zero
    );
endinterface

// File: rtl/binary_divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module binary_divider_seq #(
    parameter int n = 4
) (
    input logic                 clk,
    input logic                 rst,
    binary_divider_seq_if.slave bus
);
    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  rem_q, rem_d;
    logic [n-1:0]  quo_q, quo_d;
    logic [n-1:0]  b_q, b_d;
    logic [n-1:0]  q_q, q_d;
    logic [n-1:0]  r_q, r_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;

    logic [n:0]    rem_sh;
    logic [n:0]    diff;
    logic [n-1:0]  rem_it;
    logic [n-1:0]  quo_it;
    logic [n-1:0]  a_core;
    logic [n-1:0]  b_core;
    logic [n-1:0]  q_fin;
    logic [n-1:0]  r_fin;

    // Trial subtraction is done at n+1 bits so the borrow lands in diff[n].
    assign rem_sh = {rem_q, quo_q[n-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign quo_it = {quo_q[n-2:0], ~diff[n]};
    assign rem_it = diff[n] ? rem_sh[n-1:0] : diff[n-1:0];

`ifdef DIV_SIGNED_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;

    function automatic logic [n-1:0] neg(input logic [n-1:0] v);
        return ~v + {{(n-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [n-1:0] mag(input logic [n-1:0] v);
        return v[n-1] ? neg(v) : v;
    endfunction

    // Most-negative magnitude stays 100..0, which the unsigned core reads as 2^(n-1).
    assign a_core = mag(bus.A);
    assign b_core = mag(bus.B);
    assign q_fin  = (sa_q ^ sb_q) ? neg(quo_it) : quo_it;
    assign r_fin  = sa_q ? neg(rem_it) : rem_it;
`else
    assign a_core = bus.A;
    assign b_core = bus.B;
    assign q_fin  = quo_it;
    assign r_fin  = rem_it;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.B != '0) begin
                        b_d     = b_core;
                        rem_d   = '0;
                        quo_d   = a_core;
                        cnt_d   = CW'(n);
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                        sa_d    = bus.A[n-1];
                        sb_d    = bus.B[n-1];
`endif
                        state_d = RUN;
                    end else begin
                        q_d     = '1;
                        r_d     = bus.A;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                rem_d = rem_it;
                quo_d = quo_it;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    q_d     = q_fin;
                    r_d     = r_fin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule
